snx_io: RTL and testbench
=========================

Name: snx_io

Overview:
Memory-mapped I/O peripheral for the SNX 16-bit core. It sits directly downstream of the core's data-memory port and decodes the upper half of the address space (adrs[15]=1). Data RAM handles the lower half.
It holds the LED output register, a synchronised and debounced 8-bit switch input, and a 16-bit prescaled free-running timer. It returns registered read data to the core's datai mux.

Parameters:
DEBOUNCE, 4, consecutive stable cycles before a switch change is accepted (>=2)
PRESCALE, 10, m_clock cycles per timer tick (>=1)

Ports:
m_clock  in  1  system clock, all state on rising edge
p_reset  in  1  synchronous active-high reset
adrs  in  16  core data address
datao  in  16  core write data
memory_read  in  1  core load strobe
memory_write  in  1  core store strobe
sw_in  in  8  asynchronous board switches
datai_io  out  16  registered read data, muxed by top level when io_sel=1
io_sel  out  1  registered: previous cycle was an I/O read
led  out  8  LED register

Behaviour:
- Reset (p_reset=1 at an edge): led=0, datai_io=0, io_sel=0, sw_stable=0, sync flops=0, debounce counter=0, timer count=0, prescaler=0, en=0, ovf=0. Reset mid-operation aborts any pending read; io_sel=0 the next cycle.
- Select: hit = adrs[15]. Register index = adrs[1:0]; adrs[14:2] ignored, so registers alias.
- Map:
  - 0 = SW: read only; returns {8'h00, sw_stable}.
  - 1 = LED: read/write; a write loads led <= datao[7:0].
  - 2 = COUNT: read only; returns the 16-bit timer count.
  - 3 = CTRL/STATUS: a write sets en <= datao[0]; datao[1]=1 clears count and prescaler. A read returns {14'b0, ovf, en}.
- Writes to SW or COUNT are ignored.
- Read latency is 1 cycle. On an edge with memory_read && hit: datai_io <= selected value sampled before any same-edge update, and io_sel <= 1. Otherwise io_sel <= 0 and datai_io holds.
- memory_read and memory_write together: the write is performed and the read returns the pre-write value.
- Strobes with adrs[15]=0: no state change, io_sel=0.
- Switch path: 2-flop synchroniser sync2 <= sync1 <= sw_in. The debounce counter resets to 0 whenever sync2 == sw_stable, otherwise it increments. When the counter is DEBOUNCE-1 and sync2 != sw_stable: sw_stable <= sync2 and the counter resets. The whole byte is debounced as one word; a glitch shorter than DEBOUNCE cycles never reaches sw_stable.
- Timer:
  - While en=1, the prescaler counts 0..PRESCALE-1; tick occurs at PRESCALE-1, then the prescaler wraps to 0.
  - On tick, count <= count+1 (mod 2^16).
  - The 0xFFFF->0x0000 wrap sets ovf (sticky).
  - en=0 freezes both the prescaler and count.
- Timer boundary rules:
  - A clear via CTRL bit1 on the same edge as a tick wins: count=0 and ovf is not set by that tick.
  - A CTRL write with bit1 does not clear ovf.
  - A STATUS read clears ovf. If an overflow occurs on the same edge, ovf stays 1 (set wins). The read data shows the pre-edge ovf.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package snx_pkg: register index constants IO_SW=2'd0, IO_LED=2'd1, IO_CNT=2'd2, IO_CTRL=2'd3; IO_BASE_BIT=15; CTRL bit positions CTRL_EN=0, CTRL_CLR=1; STATUS_OVF=1.
- One sub-module, snx_debounce (parameter WIDTH=8 and DEBOUNCE; ports m_clock, p_reset, din, dout). It holds the synchroniser, counter and stable register. The timer and register file stay inline.

Test Plan:
- Reset then store 16'h00A5 to 16'h8001 -> led=8'hA5 next cycle. Load 16'h8001 -> datai_io=16'h00A5 and io_sel=1 one cycle after the strobe.
- sw_in=8'h34 held (DEBOUNCE=4) -> sw_stable=8'h34 exactly 2+4 cycles after the change; load 16'h8000 returns 16'h0034. A 3-cycle pulse to 8'hFF leaves 16'h0034.
- Store 16'h0001 to 16'h8003 with PRESCALE=10, run 100 cycles -> load 16'h8002 returns 16'h000A. Store 16'h0000 -> count frozen over 50 more cycles.
- Force count to 16'hFFFF, then one tick -> count=16'h0000. Load 16'h8003 returns 16'h0003; a second load returns 16'h0001.
- Store 16'h0003 to 16'h8003 on the same edge as a tick -> count=0, ovf unchanged. Store 16'h0055 to 16'h0001 (adrs[15]=0) -> led unchanged, io_sel stays 0.
- memory_read and memory_write to 16'h8001 with datao=16'h00FF while led=8'h12 -> datai_io=16'h0012, led=8'hFF. Assert p_reset during a read -> io_sel=0 and all registers at reset values.

Source files
------------

// File: rtl/snx_pkg.sv
// snx_pkg: shared constants for the SNX memory-mapped I/O block.
// Register indices, address decode bit and CTRL/STATUS bit positions.
package snx_pkg;

  typedef enum logic [1:0] {
    IO_SW   = 2'd0,
    IO_LED  = 2'd1,
    IO_CNT  = 2'd2,
    IO_CTRL = 2'd3
  } io_reg_e;

  localparam int IO_BASE_BIT = 15;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int STATUS_OVF  = 1;

  function automatic logic [15:0] status_word(
    input logic ovf,
    input logic en
  );
    logic [15:0] s;
    s = '0;
    s[STATUS_OVF] = ovf;
    s[CTRL_EN]    = en;
    return s;
  endfunction

endpackage

// File: rtl/snx_debounce.sv
// snx_debounce: 2-flop synchroniser plus whole-word debouncer.
// Ports: m_clock, p_reset (sync, high), din (async), dout (stable word).
module snx_debounce #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt;

  // cnt counts consecutive cycles that sync2 differs from dout,
  // regardless of which differing value it holds.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      sync1 <= '0;
      sync2 <= '0;
      cnt   <= '0;
      dout  <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/snx_io.sv
// snx_io: I/O peripheral in the upper half of the SNX data space.
// Ports: bus (adrs, datao, strobes), sw_in, datai_io/io_sel, led.
module snx_io
  import snx_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int PRESCALE = 10
) (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic [15:0] adrs,
  input  logic [15:0] datao,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [7:0]  sw_in,
  output logic [15:0] datai_io,
  output logic        io_sel,
  output logic [7:0]  led
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic          hit;
  logic          rd;
  logic          wr;
  io_reg_e       idx;
  logic [7:0]    sw_stable;
  logic [15:0]   count;
  logic [PW-1:0] pre;
  logic          en;
  logic          ovf;
  logic          tick;
  logic          clr;
  logic          ovf_set;
  logic          rd_stat;
  logic [15:0]   rd_val;
  logic          unused_bits;

  // adrs[14:2] alias, datao high byte has no destination.
  assign unused_bits = ^{adrs[14:2], datao[15:8]};

  assign hit = adrs[IO_BASE_BIT];
  assign idx = io_reg_e'(adrs[1:0]);
  assign rd  = memory_read && hit;
  assign wr  = memory_write && hit;

  snx_debounce #(
    .WIDTH    (8),
    .DEBOUNCE (DEBOUNCE)
  ) u_deb (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .din     (sw_in),
    .dout    (sw_stable)
  );

  assign tick = en && (pre == PLAST);
  assign clr  = wr && (idx == IO_CTRL)
             && datao[CTRL_CLR];
  // A clear on the wrap edge suppresses the overflow.
  assign ovf_set = tick && (count == 16'hFFFF)
                && !clr;
  assign rd_stat = rd && (idx == IO_CTRL);

  always_comb begin
    rd_val = '0;
    unique case (idx)
      IO_SW:   rd_val = {8'h00, sw_stable};
      IO_LED:  rd_val = {8'h00, led};
      IO_CNT:  rd_val = count;
      IO_CTRL: rd_val = status_word(ovf, en);
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      datai_io <= '0;
      io_sel   <= 1'b0;
      led      <= '0;
      count    <= '0;
      pre      <= '0;
      en       <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      io_sel <= rd;
      if (rd) begin
        datai_io <= rd_val;
      end
      if (wr && (idx == IO_LED)) begin
        led <= datao[7:0];
      end
      if (wr && (idx == IO_CTRL)) begin
        en <= datao[CTRL_EN];
      end
      if (clr) begin
        count <= '0;
        pre   <= '0;
      end else if (en) begin
        pre <= tick ? '0 : pre + PW'(1);
        if (tick) begin
          count <= count + 16'd1;
        end
      end
      // Set wins over the read-to-clear.
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (rd_stat) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snx_io.sv
// tb_snx_io: random + directed bench for snx_io against a
// behavioural model (two instances: slow timer and fast timer).
module tb_snx_io;

  typedef struct {
    logic [15:0] adrs;
    logic [15:0] datao;
    logic        rd;
    logic        wr;
    logic [7:0]  sw;
  } in_t;

  typedef struct {
    logic [7:0]  led;
    logic [15:0] rdata;
    logic        iosel;
    logic        en;
    logic        ovf;
    longint      total;
    logic [7:0]  stable;
    int          mism;
    logic [7:0]  s1;
    logic [7:0]  s2;
  } m_t;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  in_t  in0 = '{16'h0, 16'h0, 1'b0, 1'b0, 8'h0};
  in_t  in1 = '{16'h0, 16'h0, 1'b0, 1'b0, 8'h0};
  m_t   m0;
  m_t   m1;

  logic [15:0] dat0, dat1;
  logic        sel0, sel1;
  logic [7:0]  led0, led1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  snx_io #(.DEBOUNCE(4), .PRESCALE(10)) u0 (
    .m_clock      (clk),
    .p_reset      (rst0),
    .adrs         (in0.adrs),
    .datao        (in0.datao),
    .memory_read  (in0.rd),
    .memory_write (in0.wr),
    .sw_in        (in0.sw),
    .datai_io     (dat0),
    .io_sel       (sel0),
    .led          (led0)
  );

  snx_io #(.DEBOUNCE(2), .PRESCALE(1)) u1 (
    .m_clock      (clk),
    .p_reset      (rst1),
    .adrs         (in1.adrs),
    .datao        (in1.datao),
    .memory_read  (in1.rd),
    .memory_write (in1.wr),
    .sw_in        (in1.sw),
    .datai_io     (dat1),
    .io_sel       (sel1),
    .led          (led1)
  );

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h at %0t",
                  name, act, exp, $time);
  endtask

  // Timer seen as "enabled edges since last clear"; the count is
  // the number of whole prescale periods in that total.
  function automatic logic [15:0] cnt_of(longint t, int p);
    return 16'((t / p) % 65536);
  endfunction

  function automatic m_t step(m_t m, in_t i, logic r,
                              int p, int d);
    m_t n;
    logic hit;
    logic [1:0] ix;
    logic [15:0] v;
    longint tb, ta;
    logic wrapped;
    n = m;
    wrapped = 1'b0;
    if (r) begin
      n.led = 0; n.rdata = 0; n.iosel = 0;
      n.en = 0; n.ovf = 0; n.total = 0;
      n.stable = 0; n.mism = 0; n.s1 = 0; n.s2 = 0;
      return n;
    end
    hit = i.adrs[15];
    ix  = i.adrs[1:0];
    case (ix)
      2'd0:    v = {8'h00, m.stable};
      2'd1:    v = {8'h00, m.led};
      2'd2:    v = cnt_of(m.total, p);
      default: v = {14'b0, m.ovf, m.en};
    endcase
    n.iosel = i.rd && hit;
    if (n.iosel) n.rdata = v;
    if (i.wr && hit && ix == 2'd3 && i.datao[1]) begin
      n.total = 0;
    end else if (m.en) begin
      tb = m.total / p;
      n.total = m.total + 1;
      ta = n.total / p;
      if (ta != tb && ta % 65536 == 0) wrapped = 1'b1;
    end
    if (wrapped) n.ovf = 1'b1;
    else if (i.rd && hit && ix == 2'd3) n.ovf = 1'b0;
    if (i.wr && hit && ix == 2'd3) n.en = i.datao[0];
    if (i.wr && hit && ix == 2'd1) n.led = i.datao[7:0];
    if (m.s2 == m.stable) n.mism = 0;
    else if (m.mism == d - 1) begin
      n.stable = m.s2;
      n.mism = 0;
    end else n.mism = m.mism + 1;
    n.s2 = m.s1;
    n.s1 = i.sw;
    return n;
  endfunction

  // Per-cycle compare of both instances against the model.
  always begin
    @(posedge clk);
    m0 = step(m0, in0, rst0, 10, 4);
    m1 = step(m1, in1, rst1, 1, 2);
    #1;
    chk("led0", {8'h0, led0}, {8'h0, m0.led});
    chk("sel0", {15'h0, sel0}, {15'h0, m0.iosel});
    chk("dat0", dat0, m0.rdata);
    chk("led1", {8'h0, led1}, {8'h0, m1.led});
    chk("sel1", {15'h0, sel1}, {15'h0, m1.iosel});
    chk("dat1", dat1, m1.rdata);
  end

  task automatic drv0(input logic [15:0] a,
                      input logic [15:0] d,
                      input logic r, input logic w);
    in0.adrs = a; in0.datao = d;
    in0.rd = r; in0.wr = w;
    @(negedge clk);
    in0.rd = 1'b0; in0.wr = 1'b0;
  endtask

  task automatic drv1(input logic [15:0] a,
                      input logic [15:0] d,
                      input logic r, input logic w);
    in1.adrs = a; in1.datao = d;
    in1.rd = r; in1.wr = w;
    @(negedge clk);
    in1.rd = 1'b0; in1.wr = 1'b0;
  endtask

  task automatic idle0(input int n);
    for (int k = 0; k < n; k++) drv0(16'h0, 16'h0, 0, 0);
  endtask

  task automatic main_seq();
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    chk("rst_led", {8'h0, led0}, 16'h0000);
    chk("rst_sel", {15'h0, sel0}, 16'h0000);
    chk("rst_dat", dat0, 16'h0000);
    drv0(16'h8001, 16'h00A5, 0, 1);
    chk("led_wr", {8'h0, led0}, 16'h00A5);
    drv0(16'h8001, 16'h0, 1, 0);
    chk("led_rd", dat0, 16'h00A5);
    chk("led_sel", {15'h0, sel0}, 16'h0001);
    // switch change lands exactly on the 6th edge
    in0.sw = 8'h34;
    idle0(5);
    drv0(16'h8000, 16'h0, 1, 0);
    chk("sw_early", dat0, 16'h0000);
    drv0(16'h8000, 16'h0, 1, 0);
    chk("sw_34", dat0, 16'h0034);
    in0.sw = 8'hFF;
    idle0(3);
    in0.sw = 8'h34;
    idle0(10);
    drv0(16'hFFF0, 16'h0, 1, 0);
    chk("sw_glitch", dat0, 16'h0034);
    // timer: 100 enabled edges at prescale 10
    drv0(16'h8003, 16'h0001, 0, 1);
    idle0(100);
    drv0(16'h8002, 16'h0, 1, 0);
    chk("cnt_10", dat0, 16'h000A);
    drv0(16'h8003, 16'h0000, 0, 1);
    idle0(50);
    drv0(16'h8002, 16'h0, 1, 0);
    chk("cnt_frz", dat0, 16'h000A);
    // total is 102 here: 8th enabled edge is a tick
    drv0(16'h8003, 16'h0001, 0, 1);
    idle0(7);
    drv0(16'h8003, 16'h0003, 0, 1);
    drv0(16'h8002, 16'h0, 1, 0);
    chk("clr_tick", dat0, 16'h0000);
    drv0(16'h8003, 16'h0, 1, 0);
    chk("stat_en", dat0, 16'h0001);
    drv0(16'h0001, 16'h0055, 0, 1);
    chk("nohit_led", {8'h0, led0}, 16'h00A5);
    drv0(16'h0001, 16'h0, 1, 0);
    chk("nohit_sel", {15'h0, sel0}, 16'h0000);
    drv0(16'h8001, 16'h0012, 0, 1);
    drv0(16'h8001, 16'h00FF, 1, 1);
    chk("rw_dat", dat0, 16'h0012);
    chk("rw_led", {8'h0, led0}, 16'h00FF);
    rst0 = 1'b1;
    drv0(16'h8002, 16'h0, 1, 0);
    rst0 = 1'b0;
    chk("rrd_sel", {15'h0, sel0}, 16'h0000);
    chk("rrd_led", {8'h0, led0}, 16'h0000);
    chk("rrd_dat", dat0, 16'h0000);
    for (int k = 0; k < 3000; k++) begin
      in0.adrs = {1'($urandom_range(0, 3) != 0),
                  13'($urandom), 2'($urandom)};
      in0.datao = 16'($urandom);
      in0.rd = 1'($urandom);
      in0.wr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) in0.sw = 8'($urandom);
      rst0 = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst0 = 1'b0;
    in0.rd = 1'b0; in0.wr = 1'b0;
  endtask

  task automatic fast_seq();
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    drv1(16'h8003, 16'h0001, 0, 1);
    for (int k = 0; k < 65535; k++) begin
      if (k % 53 == 0) in1.sw = 8'($urandom);
      in1.adrs = 16'h0;
      @(negedge clk);
    end
    drv1(16'h8002, 16'h0, 1, 0);
    chk("cnt_ffff", dat1, 16'hFFFF);
    drv1(16'h8003, 16'h0003, 0, 1);
    drv1(16'h8003, 16'h0, 1, 0);
    chk("stat_ovf", dat1, 16'h0003);
    drv1(16'h8003, 16'h0, 1, 0);
    chk("stat_clr", dat1, 16'h0001);
    drv1(16'h8002, 16'h0, 1, 0);
    chk("cnt_after", dat1, 16'h0002);
  endtask

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: run did not end, got %0d want 0",
             $time);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      main_seq();
      fast_seq();
    join
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
